// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    // Upper bounds for the generic write-priority resolver
    localparam int MAX_WPORTS = 8;
    localparam int MAX_AW     = 16;
    localparam int PORT_IDX_W = $clog2(MAX_WPORTS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    typedef struct packed {
        logic                  hit;
        logic [PORT_IDX_W-1:0] port;
    } wr_sel_t;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

    // Winning write port for address a: the highest-indexed enabled port
    // targeting a. Ports above the instantiated count must arrive with we=0.
    function automatic wr_sel_t resolve_wr(
        input logic [MAX_WPORTS-1:0]             we,
        input logic [MAX_WPORTS-1:0][MAX_AW-1:0] wa,
        input logic [MAX_AW-1:0]                 a
    );
        wr_sel_t sel;
        sel = '0;
        for (int p = 0; p < MAX_WPORTS; p++) begin
            if (we[p] && wa[p] == a) begin
                sel.hit  = 1'b1;
                sel.port = PORT_IDX_W'(p);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks a pointer over every register, one per cycle.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter  int N_REG = 32,
    localparam int AW    = addr_w(N_REG)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_e    state;
    logic [AW-1:0] ptr;

    // Start on clr from IDLE; stop after the last register has been written
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    if (ptr == AW'(N_REG - 1)) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp_arstn.sv
// Multi-port register file with write priority, optional bypass,
// optional registered reads, optional zero register and a clear sequencer.
module regfile_mp_arstn
    import regfile_pkg::*;
#(
    parameter  int               WIDTH      = 32,
    parameter  int               N_REG      = 32,
    parameter  int               N_RPORTS   = 2,
    parameter  int               N_WPORTS   = 1,
    parameter  int               RD_LATENCY = 0,
    parameter  int               BYPASS     = 1,
    parameter  int               ZERO_REG   = 0,
    parameter  logic [WIDTH-1:0] RESET_VAL  = '0,
    localparam int               AW         = addr_w(N_REG)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_RPORTS-1:0][AW-1:0]    raddr,
    input  logic [N_RPORTS-1:0]            ren,
    output logic [N_RPORTS-1:0][WIDTH-1:0] rdata,
    input  logic [N_WPORTS-1:0][AW-1:0]    waddr,
    input  logic [N_WPORTS-1:0]            wen,
    input  logic [N_WPORTS-1:0][WIDTH-1:0] wdata,
    input  logic                           clr,
    output logic                           busy
);

    logic [WIDTH-1:0]                   mem [N_REG];
    logic                               clr_we;
    logic [AW-1:0]                      clr_addr;
    logic [MAX_WPORTS-1:0]              acc_we;
    logic [MAX_WPORTS-1:0][MAX_AW-1:0]  wa_ext;
    wr_sel_t                            wsel [N_REG];
    wr_sel_t                            rsel;
    logic [N_RPORTS-1:0][WIDTH-1:0]     rd_val;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (N_REG == (1 << AW)) || (32'(a) < 32'(N_REG));
    endfunction

    function automatic logic [WIDTH-1:0] pick_wdata(input logic [PORT_IDX_W-1:0] port);
        logic [WIDTH-1:0] d;
        d = '0;
        for (int p = 0; p < N_WPORTS; p++) begin
            if (int'(port) == p) d = wdata[p];
        end
        return d;
    endfunction

    regfile_clr_seq #(
        .N_REG (N_REG)
    ) u_clr_seq (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Qualify port writes: out-of-range, hardwired-zero and in-clear writes are dropped
    always_comb begin
        acc_we = '0;
        wa_ext = '0;
        for (int p = 0; p < N_WPORTS; p++) begin
            wa_ext[p] = MAX_AW'(waddr[p]);
            acc_we[p] = wen[p] && in_range(waddr[p]) &&
                        !(ZERO_REG != 0 && waddr[p] == '0) && !busy;
        end
    end

    // Per-register winning port
    always_comb begin
        for (int r = 0; r < N_REG; r++) begin
            wsel[r] = resolve_wr(acc_we, wa_ext, MAX_AW'(r));
        end
    end

    // Storage: clear writes own the array while busy, port writes otherwise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < N_REG; r++) mem[r] <= RESET_VAL;
        end else if (clr_we) begin
            mem[clr_addr] <= RESET_VAL;
        end else begin
            for (int r = 0; r < N_REG; r++) begin
                if (wsel[r].hit) mem[r] <= pick_wdata(wsel[r].port);
            end
        end
    end

    // Read value: masked for out-of-range / zero register, port writes forwarded if enabled
    always_comb begin
        rsel   = '0;
        rd_val = '0;
        for (int j = 0; j < N_RPORTS; j++) begin
            if (in_range(raddr[j]) && !(ZERO_REG != 0 && raddr[j] == '0)) begin
                rd_val[j] = mem[raddr[j]];
                if (BYPASS != 0) begin
                    rsel = resolve_wr(acc_we, wa_ext, MAX_AW'(raddr[j]));
                    if (rsel.hit) rd_val[j] = pick_wdata(rsel.port);
                end
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_rd_reg
            logic [N_RPORTS-1:0][WIDTH-1:0] rdata_p1;

            // Registered read stage: load on ren, hold otherwise
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    rdata_p1 <= '0;
                end else begin
                    for (int j = 0; j < N_RPORTS; j++) begin
                        if (ren[j]) rdata_p1[j] <= rd_val[j];
                    end
                end
            end

            assign rdata = rdata_p1;
        end else begin : g_rd_comb
            logic unused_ren;
            assign unused_ren = ^ren;
            assign rdata      = rd_val;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp_arstn.sv
// Bench: three register-file configurations driven by one shared stimulus,
// each checked every cycle against a behavioural model, plus literal checks.
module tb_regfile_mp_arstn;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic [1:0][4:0]  ra;
    logic [1:0][4:0]  wa;
    logic [1:0][2:0]  ra3;
    logic [1:0][2:0]  wa3;
    logic [1:0]       ren;
    logic [1:0]       wen;
    logic [1:0][31:0] wd;
    logic             clr;
    logic [1:0][31:0] rdo [3];
    logic             bsy [3];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Model state: contents, remaining clear cycles, registered read data
    logic [31:0] mm  [3][24];
    int          bl  [3];
    logic [31:0] mrd [3][2];

    always #5 clk = ~clk;

    assign ra3 = {ra[1][2:0], ra[0][2:0]};
    assign wa3 = {wa[1][2:0], wa[0][2:0]};

    // d0: 24 regs, comb read, bypass, zero register
    regfile_mp_arstn #(.WIDTH(32), .N_REG(24), .N_RPORTS(2), .N_WPORTS(2), .RD_LATENCY(0),
                       .BYPASS(1), .ZERO_REG(1), .RESET_VAL(RV)) d0 (
        .clk(clk), .rstn(rstn), .raddr(ra), .ren(ren), .rdata(rdo[0]),
        .waddr(wa), .wen(wen), .wdata(wd), .clr(clr), .busy(bsy[0]));

    // d1: 8 regs, registered read, bypass
    regfile_mp_arstn #(.WIDTH(32), .N_REG(8), .N_RPORTS(2), .N_WPORTS(2), .RD_LATENCY(1),
                       .BYPASS(1), .ZERO_REG(0), .RESET_VAL(RV)) d1 (
        .clk(clk), .rstn(rstn), .raddr(ra3), .ren(ren), .rdata(rdo[1]),
        .waddr(wa3), .wen(wen), .wdata(wd), .clr(clr), .busy(bsy[1]));

    // d2: 8 regs, comb read, no bypass
    regfile_mp_arstn #(.WIDTH(32), .N_REG(8), .N_RPORTS(2), .N_WPORTS(2), .RD_LATENCY(0),
                       .BYPASS(0), .ZERO_REG(0), .RESET_VAL(RV)) d2 (
        .clk(clk), .rstn(rstn), .raddr(ra3), .ren(ren), .rdata(rdo[2]),
        .waddr(wa3), .wen(wen), .wdata(wd), .clr(clr), .busy(bsy[2]));

    function automatic int nreg(input int i); return (i == 0) ? 24 : 8; endfunction
    function automatic bit rl(input int i);   return i == 1;            endfunction
    function automatic bit byp(input int i);  return i != 2;            endfunction
    function automatic bit zr(input int i);   return i == 0;            endfunction

    function automatic int adr(input int i, input logic [4:0] a);
        return (i == 0) ? int'(a) : int'(a[2:0]);
    endfunction

    function automatic bit m_acc(input int i, input int p);
        int a;
        a = adr(i, wa[p]);
        return wen[p] && (a < nreg(i)) && !(zr(i) && a == 0) && (bl[i] == 0);
    endfunction

    function automatic logic [31:0] m_read(input int i, input int a);
        logic [31:0] v;
        if (a >= nreg(i) || (zr(i) && a == 0)) return 32'h0;
        v = mm[i][a];
        if (byp(i)) begin
            for (int p = 0; p < 2; p++)
                if (m_acc(i, p) && adr(i, wa[p]) == a) v = wd[p];
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model update
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) begin
                for (int r = 0; r < 24; r++) mm[i][r] <= RV;
                bl[i]     <= 0;
                mrd[i][0] <= '0;
                mrd[i][1] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++)
                    if (rl(i) && ren[j]) mrd[i][j] <= m_read(i, adr(i, ra[j]));
                if (bl[i] > 0) begin
                    mm[i][nreg(i) - bl[i]] <= RV;
                    bl[i] <= bl[i] - 1;
                end else begin
                    for (int p = 0; p < 2; p++)
                        if (m_acc(i, p)) mm[i][adr(i, wa[p])] <= wd[p];
                    if (clr) bl[i] <= nreg(i);
                end
            end
        end
    end

    // Compare every DUT against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("d%0d_busy", i), 32'(bsy[i]), 32'(bl[i] > 0));
                for (int j = 0; j < 2; j++)
                    chk($sformatf("d%0d_rdata%0d", i, j), rdo[i][j],
                        rl(i) ? mrd[i][j] : m_read(i, adr(i, ra[j])));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, c2;
        ra = '0; wa = '0; ren = '0; wen = '0; wd = '0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk_en = 1'b1;

        // Reset contents and idle state
        ra[0] = 5'd1; ra[1] = 5'd7;
        #2;
        chk("reset_d0_p0", rdo[0][0], RV);
        chk("reset_d0_p1", rdo[0][1], RV);
        chk("reset_d2_p0", rdo[2][0], RV);
        chk("reset_d1_reg", rdo[1][0], 32'h0);
        chk("reset_busy", 32'(bsy[0]), 32'h0);
        next_cycle();

        // Same-address conflict between both write ports
        wen = 2'b11; wa[0] = 5'd5; wa[1] = 5'd5; wd[0] = 32'h11; wd[1] = 32'h22;
        ra[0] = 5'd5; ren = 2'b11;
        #2;
        chk("conflict_bypass", rdo[0][0], 32'h22);
        chk("conflict_nobypass", rdo[2][0], RV);
        next_cycle();
        wen = '0; ren = '0;
        #2;
        chk("conflict_stored_d0", rdo[0][0], 32'h22);
        chk("conflict_stored_d2", rdo[2][0], 32'h22);
        chk("conflict_reg_d1", rdo[1][0], 32'h22);
        next_cycle();

        // Registered read with bypass, then hold with ren=0
        wen = 2'b01; wa[0] = 5'd3; wd[0] = 32'hA5; ren = 2'b01; ra[0] = 5'd3;
        next_cycle();
        wen = '0; ren = '0; ra[0] = 5'd4;
        #2;
        chk("regread_bypass", rdo[1][0], 32'hA5);
        next_cycle();
        #2;
        chk("regread_hold", rdo[1][0], 32'hA5);
        next_cycle();

        // Zero register and out-of-range read
        wen = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; ra[0] = 5'd0; ra[1] = 5'd30;
        #2;
        chk("zero_bypass", rdo[0][0], 32'h0);
        chk("oor_read", rdo[0][1], 32'h0);
        next_cycle();
        wen = '0;
        #2;
        chk("zero_read", rdo[0][0], 32'h0);
        next_cycle();

        // Clear: busy length, dropped write, ignored second clr
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        c0 = 0; c2 = 0;
        for (int t = 0; t < 40; t++) begin
            wen = (t == 1) ? 2'b01 : 2'b00;
            wa[0] = 5'd2; wd[0] = 32'h1234;
            clr = (t == 3);
            #2;
            if (bsy[0]) c0++;
            if (bsy[2]) c2++;
            next_cycle();
        end
        wen = '0; clr = 1'b0;
        chk("clear_len_8", 32'(c2), 32'd8);
        chk("clear_len_24", 32'(c0), 32'd24);
        for (int r = 0; r < 8; r++) begin
            ra[0] = 5'(r);
            #2;
            chk($sformatf("cleared_d2_r%0d", r), rdo[2][0], RV);
            chk($sformatf("cleared_d0_r%0d", r), rdo[0][0], (r == 0) ? 32'h0 : RV);
            next_cycle();
        end

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            for (int j = 0; j < 2; j++) begin
                ra[j]  = 5'($urandom_range(0, 31));
                wa[j]  = 5'($urandom_range(0, 31));
                wd[j]  = $urandom();
            end
            if ($urandom_range(0, 3) == 0) wa[1] = wa[0];
            ren = 2'($urandom());
            wen = 2'($urandom());
            clr = ($urandom_range(0, 63) == 0);
            next_cycle();
        end
        clr = 1'b0; wen = '0;
        repeat (30) next_cycle();

        // Asynchronous reset in the 4th busy cycle
        wen = 2'b01; wa[0] = 5'd3; wd[0] = 32'h77; ren = 2'b01; ra[0] = 5'd3;
        next_cycle();
        wen = '0; ren = '0; clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        repeat (3) next_cycle();
        #1 rstn = 1'b0;
        #1;
        chk("arst_busy_d2", 32'(bsy[2]), 32'h0);
        chk("arst_busy_d0", 32'(bsy[0]), 32'h0);
        chk("arst_rdata_d1", rdo[1][0], 32'h0);
        next_cycle();
        rstn = 1'b1;
        for (int r = 0; r < 8; r++) begin
            ra[0] = 5'(r);
            #2;
            chk($sformatf("arst_d2_r%0d", r), rdo[2][0], RV);
            chk("arst_d1_hold", rdo[1][0], 32'h0);
            next_cycle();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
